// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and
// latency-counter width.
package mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage for the responder: one synchronous write port (shared by
// commit and preload) and one asynchronous read port. Contents survive reset.
module mem_array #(
    parameter int WORD_SIZE  = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WORD_SIZE-1:0]  i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WORD_SIZE-1:0]  o_rdata
);

    logic [WORD_SIZE-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Single write port; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Latency-accurate memory responder for the multi-cycle CPU interface.
// Requests are latched in IDLE, counted down, then held in a DONE state
// until the CPU drops its request line (four-phase handshake).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int DEPTH_LOG2    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput,
    output logic                 protocolError,
    input  logic                 loadEn,
    input  logic [WORD_SIZE-1:0] loadAddr,
    input  logic [WORD_SIZE-1:0] loadData
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [WORD_SIZE-1:0]  r_wdata;
    logic                  r_perr;

    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_accept;
    logic                  w_commit;
    logic                  w_preload;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic [WORD_SIZE-1:0]  w_wdata;
    logic [WORD_SIZE-1:0]  w_rdata;
    logic                  w_ready;
    logic                  w_ack;
    logic                  w_drive;
    logic                  w_unused_upper;

    assign w_rd_req = readM & ~writeM;
    assign w_wr_req = writeM & ~readM;
    assign w_accept = (r_state == ST_IDLE) & (w_rd_req | w_wr_req);

    // Address bits above the storage depth alias onto the low words
    assign w_unused_upper = ^{address[WORD_SIZE-1:DEPTH_LOG2], loadAddr[WORD_SIZE-1:DEPTH_LOG2]};

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept, count down, wait for request drop
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_req) begin
                    w_next_state = (READ_LATENCY == 1) ? ST_RD_DONE : ST_RD_WAIT;
                end else if (w_wr_req) begin
                    w_next_state = (WRITE_LATENCY == 1) ? ST_WR_DONE : ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: if (r_cnt == CNT_W'(1)) w_next_state = ST_RD_DONE;
            ST_WR_WAIT: if (r_cnt == CNT_W'(1)) w_next_state = ST_WR_DONE;
            ST_RD_DONE: if (!readM)  w_next_state = ST_IDLE;
            ST_WR_DONE: if (!writeM) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Output decode; the bus is never driven while the CPU asserts writeM
    always_comb begin
        w_ready = 1'b0;
        w_ack   = 1'b0;
        w_drive = 1'b0;
        case (r_state)
            ST_RD_DONE: begin
                w_ready = 1'b1;
                w_drive = ~writeM;
            end
            ST_WR_DONE: w_ack = 1'b1;
            default: ;
        endcase
    end

    assign inputReady    = w_ready;
    assign ackOutput     = w_ack;
    assign protocolError = r_perr;
    assign data          = w_drive ? w_rdata : {WORD_SIZE{1'bz}};

    // Latency counter: loaded on accept, decremented while waiting
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req)      r_cnt <= RD_LOAD;
                    else if (w_wr_req) r_cnt <= WR_LOAD;
                end
                ST_RD_WAIT, ST_WR_WAIT: r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    // Request capture; later address/data changes are ignored until IDLE
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= address[DEPTH_LOG2-1:0];
            r_wdata <= data;
        end
    end

    // Sticky protocol error for simultaneous read and write in IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_perr <= 1'b0;
        end else if ((r_state == ST_IDLE) && readM && writeM) begin
            r_perr <= 1'b1;
        end
    end

    // Commit on the edge entering WR_DONE; with unit latency that edge is the
    // accept edge itself, so the live bus values are used. Reset blocks it.
    assign w_commit  = reset_n & (w_next_state == ST_WR_DONE) & (r_state != ST_WR_DONE);
    assign w_preload = (r_state == ST_IDLE) & ~readM & ~writeM & loadEn;
    assign w_we      = w_commit | w_preload;
    assign w_waddr   = w_commit ? ((r_state == ST_IDLE) ? address[DEPTH_LOG2-1:0] : r_addr)
                                : loadAddr[DEPTH_LOG2-1:0];
    assign w_wdata   = w_commit ? ((r_state == ST_IDLE) ? data : r_wdata) : loadData;

    mem_array #(
        .WORD_SIZE  (WORD_SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a read-data scoreboard queue.
module tb_mem_responder;

    localparam int W  = 16;
    localparam int RL = 2;
    localparam int WL = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         readM, writeM, loadEn;
    logic [W-1:0] address, loadAddr, loadData;
    logic [W-1:0] tb_d;
    logic         tb_oe;
    wire  [W-1:0] data;
    logic         inputReady, ackOutput, protocolError;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb_q[$];

    assign data = tb_oe ? tb_d : {W{1'bz}};

    always #5 clk = ~clk;

    mem_responder #(
        .WORD_SIZE     (W),
        .DEPTH_LOG2    (8),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .readM         (readM),
        .writeM        (writeM),
        .address       (address),
        .data          (data),
        .inputReady    (inputReady),
        .ackOutput     (ackOutput),
        .protocolError (protocolError),
        .loadEn        (loadEn),
        .loadAddr      (loadAddr),
        .loadData      (loadData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [W-1:0] a, input logic [W-1:0] d);
        loadEn = 1'b1; loadAddr = a; loadData = d;
        tick();
        loadEn = 1'b0;
    endtask

    // Read with optional address change after the accepting edge
    task automatic do_read(input string tag, input logic [W-1:0] a, input logic [W-1:0] exp,
                           input bit chg, input logic [W-1:0] a_alt);
        int n;
        logic [W-1:0] want;
        address = a; readM = 1'b1;
        sb_q.push_back(exp);
        tick();
        if (chg) address = a_alt;
        n = 0;
        while (!inputReady && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, W'(n), W'(RL - 1));
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        check({tag, "_data"}, data, want);
        readM = 1'b0;
        tick();
        check({tag, "_rdy_drop"}, W'(inputReady), 16'd0);
        // Bus must be released: a bench-driven value has to read back intact
        tb_oe = 1'b1; tb_d = 16'h5A5A;
        #1;
        check({tag, "_bus_free"}, data, 16'h5A5A);
        tb_oe = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [W-1:0] a, input logic [W-1:0] d);
        int n;
        address = a; tb_d = d; tb_oe = 1'b1; writeM = 1'b1;
        tick();
        n = 0;
        while (!ackOutput && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, W'(n), W'(WL - 1));
        check({tag, "_rdy"}, W'(inputReady), 16'd0);
        writeM = 1'b0; tb_oe = 1'b0;
        tick();
        check({tag, "_ack_drop"}, W'(ackOutput), 16'd0);
    endtask

    initial begin
        reset_n = 1'b0; readM = 1'b0; writeM = 1'b0; loadEn = 1'b0;
        address = '0; loadAddr = '0; loadData = '0; tb_d = '0; tb_oe = 1'b0;
        tick();
        tick();
        check("rst_ready", W'(inputReady), 16'd0);
        check("rst_ack",   W'(ackOutput), 16'd0);
        check("rst_perr",  W'(protocolError), 16'd0);
        reset_n = 1'b1;
        tick();

        preload(16'h0005, 16'hBEEF);
        preload(16'h0030, 16'hAAAA);
        preload(16'h0020, 16'h0BAD);

        do_read("rd5", 16'h0005, 16'hBEEF, 1'b0, 16'h0000);

        do_write("wr10", 16'h0010, 16'h1234);
        do_read("rd10", 16'h0010, 16'h1234, 1'b0, 16'h0000);

        do_read("rd_chg", 16'h0005, 16'hBEEF, 1'b1, 16'h0020);
        do_read("rd20", 16'h0020, 16'h0BAD, 1'b0, 16'h0000);

        // Preload strobe while a request is pending must be ignored
        loadEn = 1'b1; loadAddr = 16'h0005; loadData = 16'hDEAD;
        do_read("rd_ld", 16'h0020, 16'h0BAD, 1'b0, 16'h0000);
        loadEn = 1'b0;
        tick();
        do_read("rd5b", 16'h0005, 16'hBEEF, 1'b0, 16'h0000);

        // Simultaneous read and write in IDLE
        readM = 1'b1; writeM = 1'b1; tb_oe = 1'b1; tb_d = 16'hFFFF; address = 16'h0005;
        tick();
        tick();
        tick();
        check("both_perr",  W'(protocolError), 16'd1);
        check("both_ready", W'(inputReady), 16'd0);
        check("both_ack",   W'(ackOutput), 16'd0);
        readM = 1'b0; writeM = 1'b0; tb_oe = 1'b0;
        tick();

        do_read("rd_alias", 16'h0105, 16'hBEEF, 1'b0, 16'h0000);
        check("perr_sticky", W'(protocolError), 16'd1);

        // Reset on the edge that would commit a write to 0x0030
        address = 16'h0030; tb_d = 16'h5555; tb_oe = 1'b1; writeM = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check("abort_ready", W'(inputReady), 16'd0);
        check("abort_ack",   W'(ackOutput), 16'd0);
        check("abort_perr",  W'(protocolError), 16'd0);
        writeM = 1'b0; tb_oe = 1'b0; reset_n = 1'b1;
        tick();
        do_read("rd30", 16'h0030, 16'hAAAA, 1'b0, 16'h0000);

        check("sb_empty", W'(sb_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
